sd_spi_master: RTL and testbench
================================

Name: sd_spi_master

Overview:
- Core-side SPI master for the SD card port. Drives the SD_n_CS / SD_CK / SD_DI pins and samples SD_DO, completing the link with the sd_card emulator, which is the SPI slave.
- Gives the Next186 I/O port logic a byte-wide transmit/receive handshake.
- Has a run-time clock divider, so card init can run at about 400 kHz and data transfer can run at full speed.
- Uses SPI mode 0, MSB first, and full-duplex byte exchange.

Parameters:
- DIV_W, 8, width of the half-period divider input cfg_div.
- IDLE_MOSI, 1'b1, level driven on sd_sdi when no byte is in flight.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_div  in  DIV_W  SCK half-period = cfg_div+1 clk_sys cycles; sampled at byte start.
- cs_req  in  1  1 = card selected (sd_cs low) requested.
- tx_valid  in  1  byte offered.
- tx_data  in  8  byte to send.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid&tx_ready.
- rx_valid  out  1  one-cycle pulse when a received byte is complete.
- rx_data  out  8  last received byte; held until the next completion.
- busy  out  1  high from the acceptance cycle until the rx_valid cycle inclusive.
- sd_cs  out  1  chip select, active-low.
- sd_sck  out  1  SPI clock, idle low.
- sd_sdi  out  1  MOSI toward the card.
- sd_sdo  in  1  MISO from the card.

Behaviour:
- Reset values: sd_cs=1, sd_sck=0, sd_sdi=IDLE_MOSI, tx_ready=1, rx_valid=0, rx_data=8'h00, busy=0. Internal counters are 0 and the state is IDLE.
- Reset asserted mid-byte aborts the byte immediately. No rx_valid is produced.
- States:
  - IDLE.
  - LOW: SCK low phase.
  - HIGH: SCK high phase.
- Divider counter dcnt (DIV_W bits) and bit counter bcnt (3 bits).
- IDLE:
  - sd_cs <= ~cs_req every cycle.
  - On accept, latch tx_data into the shift register and cfg_div into div_q. Drive sd_sdi <= tx_data[7] on the next edge, set dcnt=0, bcnt=7, and go to LOW.
- LOW:
  - When dcnt==div_q: sd_sck<=1, sample rx_shift <= {rx_shift[6:0], sd_sdo}, dcnt<=0, go to HIGH.
  - Otherwise dcnt++.
- HIGH:
  - When dcnt==div_q: sd_sck<=0 and dcnt<=0.
  - If bcnt==0: rx_data <= rx_shift, rx_valid<=1, sd_sdi<=IDLE_MOSI, go to IDLE.
  - Otherwise bcnt--, sd_sdi <= next MSB, go to LOW.
- Timing: one byte occupies exactly 16*(div_q+1) cycles from the acceptance cycle to the rx_valid cycle. Minimum (div_q=0) is 16 cycles.
- Back-to-back bytes: tx_ready rises in the cycle after rx_valid. The gap between bytes is therefore one cycle at minimum, with sck low throughout.
- cs_req changes while busy are deferred; sd_cs updates in the first IDLE cycle. sd_cs never toggles within a byte.
- cfg_div changes while busy have no effect until the next byte.
- tx_valid while busy is ignored and not queued; the producer must hold it until tx_ready.
- sd_sdo is sampled only on the internal rising-SCK edge. The top level provides synchronisation.

Optional Feature:
- Macro: SD_SPI_CRC16_EN.
- When defined:
  - Extra ports crc_clr (in 1) and crc_out (out 16).
  - CRC16-CCITT (poly 0x1021, init 0x0000, MSB first) is updated bit-serially on every rising-SCK sample.
  - crc_clr forces 0x0000 in IDLE, and takes priority over an update in the same cycle.
  - Reset value is 0x0000.
- When undefined: no ports and no logic.

Decomposition:
- Package next186_sd_pkg holds:
  - State enum sd_spi_state_t {IDLE, LOW, HIGH}.
  - CRC16_POLY = 16'h1021.
  - CRC16_INIT = 16'h0000.
- One natural sub-module, sd_crc16_ser: a 1-bit-per-enable serial CRC with clr/en/din. It is instantiated only under SD_SPI_CRC16_EN.

Test Plan:
- Single byte:
  - Stimulus: cfg_div=0, cs_req=1, send 8'h40 while the slave model returns 8'hA5.
  - Required: MOSI bits are 0100_0000 on 8 rising edges, rx_valid exactly 16 cycles after acceptance, rx_data=8'hA5, sd_sdi=1 afterward.
- Slow clock:
  - Stimulus: cfg_div=31, send 8'hFF.
  - Required: each SCK high/low phase lasts 32 cycles, and the byte takes 512 cycles.
- Chip-select deferral:
  - Stimulus: cs_req 1→0 at cycle 5 of a cfg_div=0 byte.
  - Required: sd_cs stays 0 through rx_valid and goes 1 on the following cycle.
- Back-to-back:
  - Stimulus: tx_valid held high with 8'h12 then 8'h34.
  - Required: second acceptance one cycle after the first rx_valid, and sd_sck never high during the gap.
- Reset mid-byte:
  - Stimulus: reset_n low at bit 4.
  - Required: all outputs take their reset values asynchronously, no rx_valid, and a byte after release completes normally.
- CRC (SD_SPI_CRC16_EN):
  - Stimulus: crc_clr, then receive 512 bytes of 8'hFF.
  - Required: crc_out=16'h7FA1.

Source files
------------

// File: rtl/next186_sd_pkg.sv
// Shared types and constants for the Next186 SD card SPI master.
//   sd_spi_state_t : byte engine state (IDLE, LOW = SCK low phase, HIGH = SCK high phase)
//   CRC16_POLY     : CRC16-CCITT generator polynomial
//   CRC16_INIT     : CRC16 start / clear value
package next186_sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } sd_spi_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

endpackage

// File: rtl/sd_crc16_ser.sv
// Bit-serial CRC16-CCITT (MSB first), one bit per enabled cycle.
// Ports:
//   clk   in   clock (rising edge)
//   rst_n in   asynchronous active-low reset, loads CRC16_INIT
//   clr   in   synchronous clear to CRC16_INIT, wins over en
//   en    in   shift din into the CRC this cycle
//   din   in   data bit
//   crc   out  current CRC value
module sd_crc16_ser
  import next186_sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI master (mode 0, MSB first, full duplex) for the Next186 SD card port.
// One byte is exchanged per tx_valid/tx_ready handshake; the SCK half period is
// cfg_div+1 clk_sys cycles, captured when the byte is accepted.
// Optional feature macro: SD_SPI_CRC16_EN adds a CRC16-CCITT over received bits.
// Ports:
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset
//   cfg_div  in   SCK half-period minus one
//   cs_req   in   1 requests the card selected (sd_cs low)
//   tx_valid in   byte offered
//   tx_data  in   byte to send
//   tx_ready out  engine can accept a byte
//   rx_valid out  one-cycle pulse, received byte complete
//   rx_data  out  last received byte
//   busy     out  acceptance cycle through rx_valid cycle
//   sd_cs    out  card chip select, active low
//   sd_sck   out  SPI clock, idles low
//   sd_sdi   out  MOSI toward the card
//   sd_sdo   in   MISO from the card (already synchronised)
//   crc_clr  in   (SD_SPI_CRC16_EN) clear CRC while idle
//   crc_out  out  (SD_SPI_CRC16_EN) CRC16 of sampled MISO bits
module sd_spi_master
  import next186_sd_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter logic        IDLE_MOSI = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cs_req,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             sd_cs,
  output logic             sd_sck,
  output logic             sd_sdi,
`ifdef SD_SPI_CRC16_EN
  input  logic             crc_clr,
  output logic [15:0]      crc_out,
`endif
  input  logic             sd_sdo
);

  sd_spi_state_t    state;
  logic [DIV_W-1:0] dcnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bcnt;
  logic [6:0]       tx_shift;  // bits still to send after the one on sd_sdi
  logic [7:0]       rx_shift;
  logic             accept;
  logic             phase_end;

  // The rx_valid cycle is spent in IDLE but must not accept, so the next byte
  // can start no earlier than one cycle later.
  assign tx_ready  = (state == IDLE) && !rx_valid;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state != IDLE) || rx_valid || accept;
  assign phase_end = (dcnt == div_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dcnt     <= '0;
      div_q    <= '0;
      bcnt     <= 3'd0;
      tx_shift <= 7'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sd_cs    <= 1'b1;
      sd_sck   <= 1'b0;
      sd_sdi   <= IDLE_MOSI;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Chip select only follows cs_req between bytes.
          sd_cs <= ~cs_req;
          if (accept) begin
            tx_shift <= tx_data[6:0];
            div_q    <= cfg_div;
            sd_sdi   <= tx_data[7];
            dcnt     <= '0;
            bcnt     <= 3'd7;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            sd_sck   <= 1'b1;
            rx_shift <= {rx_shift[6:0], sd_sdo};
            dcnt     <= '0;
            state    <= HIGH;
          end else begin
            dcnt <= dcnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            sd_sck <= 1'b0;
            dcnt   <= '0;
            if (bcnt == 3'd0) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              sd_sdi   <= IDLE_MOSI;
              state    <= IDLE;
            end else begin
              bcnt     <= bcnt - 3'd1;
              sd_sdi   <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              state    <= LOW;
            end
          end else begin
            dcnt <= dcnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SD_SPI_CRC16_EN
  // CRC sees exactly the bits shifted into rx_shift.
  sd_crc16_ser u_crc (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .clr   (crc_clr && (state == IDLE)),
    .en    ((state == LOW) && phase_end),
    .din   (sd_sdo),
    .crc   (crc_out)
  );
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with a mode-0 SPI slave model.
// Latency is counted as the number of clk_sys edges from the acceptance edge
// to the edge that raises rx_valid, i.e. 16*(cfg_div+1).
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [7:0] cfg_div;
  logic       cs_req;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sd_cs;
  logic       sd_sck;
  logic       sd_sdi;
  logic       sd_sdo;
`ifdef SD_SPI_CRC16_EN
  logic       crc_clr;
  logic [15:0] crc_out;
`endif

  int checks = 0;
  int errors = 0;

  sd_spi_master #(
    .DIV_W     (8),
    .IDLE_MOSI (1'b1)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cfg_div  (cfg_div),
    .cs_req   (cs_req),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sd_cs    (sd_cs),
    .sd_sck   (sd_sck),
    .sd_sdi   (sd_sdi),
`ifdef SD_SPI_CRC16_EN
    .crc_clr  (crc_clr),
    .crc_out  (crc_out),
`endif
    .sd_sdo   (sd_sdo)
  );

  always #5 clk_sys = ~clk_sys;

  // Slave model: presents slv[7] before the first rising SCK and advances on
  // each falling SCK; idles high outside the byte.
  logic [7:0] slv;
  logic [7:0] mosi_cap;
  int sck_rises = 0;
  int sck_falls = 0;
  int rise_base;
  int fall_base;
  int slv_k;

  always @(posedge sd_sck) begin
    mosi_cap  <= {mosi_cap[6:0], sd_sdi};
    sck_rises <= sck_rises + 1;
  end
  always @(negedge sd_sck) sck_falls <= sck_falls + 1;

  assign slv_k  = sck_falls - fall_base;
  assign sd_sdo = (slv_k >= 0 && slv_k < 8) ? slv[3'(7 - slv_k)] : 1'b1;

  // Per-byte observations filled by xfer.
  int lat, wait_n, sck_in_wait, cs_chg;
  int hi_min, hi_max, lo_min, lo_max;
  int cs_flip_at = -1;
  int div_after  = -1;
  logic cs0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic note_run(input logic lvl, input int run);
    if (lvl) begin
      if (run < hi_min) hi_min = run;
      if (run > hi_max) hi_max = run;
    end else begin
      if (run < lo_min) lo_min = run;
      if (run > lo_max) lo_max = run;
    end
  endtask

  // Offer byte d, wait for acceptance, then sample every negedge until rx_valid.
  // Called at a negedge; returns at the negedge sample where rx_valid is high.
  task automatic xfer(input logic [7:0] d, input logic hold);
    int run;
    logic lvl;
    tx_data = d;
    tx_valid = 1'b1;
    wait_n = 0;
    sck_in_wait = 0;
    while (!tx_ready && wait_n < 1000) begin
      if (sd_sck) sck_in_wait++;
      wait_n++;
      @(negedge clk_sys);
    end
    check("tx_ready_seen", tx_ready, 1);
    if (sd_sck) sck_in_wait++;
    rise_base = sck_rises;
    fall_base = sck_falls;
    cs0 = sd_cs;
    cs_chg = 0;
    lat = 0;
    run = 0;
    lvl = 1'b0;
    hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
    @(negedge clk_sys);
    if (!hold) tx_valid = 1'b0;
    if (div_after >= 0) cfg_div = 8'(div_after);
    while (!rx_valid && lat < 20000) begin
      lat++;
      if (sd_sck == lvl) run++;
      else begin
        note_run(lvl, run);
        lvl = sd_sck;
        run = 1;
      end
      if (sd_cs != cs0) cs_chg++;
      if (lat == cs_flip_at) cs_req = 1'b0;
      @(negedge clk_sys);
    end
    note_run(lvl, run);
    if (sd_cs != cs0) cs_chg++;
    check("rx_valid_seen", rx_valid, 1);
  endtask

  initial begin
    reset_n  = 1'b0;
    cfg_div  = 8'd0;
    cs_req   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    slv      = 8'hFF;
    rise_base = 0;
    fall_base = 0;
`ifdef SD_SPI_CRC16_EN
    crc_clr  = 1'b0;
`endif

    // Reset state
    @(negedge clk_sys);
    check("rst_cs", sd_cs, 1);
    check("rst_sck", sd_sck, 0);
    check("rst_sdi", sd_sdi, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single byte, full speed
    cs_req = 1'b1;
    @(negedge clk_sys);
    check("cs_follow", sd_cs, 0);
    slv = 8'hA5;
    xfer(8'h40, 1'b0);
    check("b1_latency", lat, 16);
    check("b1_mosi", mosi_cap, 8'h40);
    check("b1_rises", sck_rises - rise_base, 8);
    check("b1_rx_data", rx_data, 8'hA5);
    check("b1_sdi_idle", sd_sdi, 1);
    check("b1_busy_at_rxv", busy, 1);
    check("b1_ready_at_rxv", tx_ready, 0);
    @(negedge clk_sys);
    check("b1_rxv_pulse", rx_valid, 0);
    check("b1_ready_after", tx_ready, 1);
    check("b1_busy_after", busy, 0);
    check("b1_rx_hold", rx_data, 8'hA5);

    // Slow clock; cfg_div changed mid-byte must not matter
    cfg_div = 8'd31;
    div_after = 0;
    slv = 8'h3C;
    xfer(8'hFF, 1'b0);
    div_after = -1;
    check("slow_latency", lat, 512);
    check("slow_hi_min", hi_min, 32);
    check("slow_hi_max", hi_max, 32);
    check("slow_lo_min", lo_min, 32);
    check("slow_lo_max", lo_max, 32);
    check("slow_mosi", mosi_cap, 8'hFF);
    check("slow_rx_data", rx_data, 8'h3C);
    @(negedge clk_sys);

    // Chip-select deferral
    cfg_div = 8'd0;
    cs_flip_at = 5;
    slv = 8'h5A;
    xfer(8'hC3, 1'b0);
    cs_flip_at = -1;
    check("cs_held_in_byte", cs_chg, 0);
    check("cs_at_rxv", sd_cs, 0);
    check("cs_rx_data", rx_data, 8'h5A);
    check("cs_mosi", mosi_cap, 8'hC3);
    @(negedge clk_sys);
    check("cs_released", sd_cs, 1);
    cs_req = 1'b1;
    @(negedge clk_sys);

    // Back-to-back with tx_valid held
    slv = 8'h9C;
    xfer(8'h12, 1'b1);
    check("b2b_first_mosi", mosi_cap, 8'h12);
    check("b2b_first_rx", rx_data, 8'h9C);
    slv = 8'h81;
    xfer(8'h34, 1'b0);
    check("b2b_gap", wait_n, 1);
    check("b2b_sck_in_gap", sck_in_wait, 0);
    check("b2b_latency", lat, 16);
    check("b2b_second_mosi", mosi_cap, 8'h34);
    check("b2b_second_rx", rx_data, 8'h81);
    @(negedge clk_sys);

    // Reset mid-byte (after the 4th rising SCK)
    slv = 8'hFF;
    rise_base = sck_rises;
    fall_base = sck_falls;
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
    for (int i = 0; i < 100 && (sck_rises - rise_base) < 4; i++) @(negedge clk_sys);
    check("mid_bit4_reached", sck_rises - rise_base, 4);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", sd_cs, 1);
    check("mid_rst_sck", sd_sck, 0);
    check("mid_rst_sdi", sd_sdi, 1);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    begin
      int rxv_seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_sys);
        if (rx_valid) rxv_seen++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk_sys);
        if (rx_valid) rxv_seen++;
      end
      check("mid_no_rx_valid", rxv_seen, 0);
    end
    check("mid_cs_back", sd_cs, 0);
    slv = 8'h66;
    xfer(8'hE7, 1'b0);
    check("post_rst_latency", lat, 16);
    check("post_rst_rx", rx_data, 8'h66);
    check("post_rst_mosi", mosi_cap, 8'hE7);
    @(negedge clk_sys);

`ifdef SD_SPI_CRC16_EN
    // CRC over 512 received 0xFF bytes
    crc_clr = 1'b1;
    @(negedge clk_sys);
    crc_clr = 1'b0;
    check("crc_cleared", crc_out, 16'h0000);
    for (int n = 0; n < 512; n++) begin
      slv = 8'hFF;
      xfer(8'hFF, 1'b0);
    end
    @(negedge clk_sys);
    check("crc_512_ff", crc_out, 16'h7FA1);
    crc_clr = 1'b1;
    @(negedge clk_sys);
    crc_clr = 1'b0;
    check("crc_clr_again", crc_out, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
